// File: rtl/shreg_pkg.sv
// Shared types for the sequential shift unit: operation codes and FSM states.
package shreg_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_SHL  = 2'b01,
      OP_SHR  = 2'b10,
      OP_ROR  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/shift_reg_seq_if.sv
// Start/ready/done request bus between a register-file producer and the shift unit.
interface shift_reg_seq_if
   import shreg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH) + 1
);
   logic             start;
   op_t              op;
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] din;
   logic             ser_in;
   logic [WIDTH-1:0] q;
   logic             ser_out;
   logic             ready;
   logic             done;

   modport master (
      output start, op, amt, din, ser_in,
      input  q, ser_out, ready, done
   );

   modport slave (
      input  start, op, amt, din, ser_in,
      output q, ser_out, ready, done
   );
endinterface

// File: rtl/shift_reg_seq_shift_step.sv
// One-position shift/rotate slice; purely combinational, zero latency.
// No backpressure: output follows inputs every cycle.
module shift_step
   import shreg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  op_t              op,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q_next,
   output logic             bit_out
);

   always_comb begin
      q_next  = q;
      bit_out = 1'b0;
      case (op)
         OP_SHL: begin
            q_next  = {q[WIDTH-2:0], ser_in};
            bit_out = q[WIDTH-1];
         end
         OP_SHR: begin
            q_next  = {ser_in, q[WIDTH-1:1]};
            bit_out = q[0];
         end
         OP_ROR: begin
            q_next  = {q[0], q[WIDTH-1:1]};
            bit_out = q[0];
         end
         default: begin
            q_next  = q;
            bit_out = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shift_reg_seq.sv
// Sequential shifter: loads a word then shifts/rotates one position per clock.
// Latency: done pulses the cycle after accept edge + amt; start is ignored while ready=0.
module shift_reg_seq
   import shreg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   shift_reg_seq_if.slave   bus
);

   state_t           state;
   state_t           state_nxt;
   op_t              op_r;
   logic [AMT_W-1:0] cnt;
   logic [WIDTH-1:0] q_r;
   logic             ser_out_r;
   logic [WIDTH-1:0] q_step;
   logic             bit_step;
   logic             accept;

   assign accept = (state == ST_IDLE) && bus.start;

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .q       (q_r),
      .op      (op_r),
      .ser_in  (bus.ser_in),
      .q_next  (q_step),
      .bit_out (bit_step)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.op == OP_LOAD || bus.amt == '0) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (cnt == AMT_W'(1)) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // q and ser_out only move on accept or on a RUN step; they hold in IDLE and DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r       <= '0;
         ser_out_r <= 1'b0;
         cnt       <= '0;
         op_r      <= OP_LOAD;
      end else if (accept) begin
         q_r       <= bus.din;
         ser_out_r <= 1'b0;
         cnt       <= bus.amt;
         op_r      <= bus.op;
      end else if (state == ST_RUN) begin
         q_r       <= q_step;
         ser_out_r <= bit_step;
         cnt       <= cnt - AMT_W'(1);
      end
   end

   assign bus.q       = q_r;
   assign bus.ser_out = ser_out_r;
   assign bus.ready   = (state == ST_IDLE);
   assign bus.done    = (state == ST_DONE);

   a_done_ready_excl : assert property (@(posedge clk) disable iff (rst)
      !(bus.done && bus.ready));

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed vector bench for shift_reg_seq at WIDTH=8, plus hand-written multi-cycle sequences.
module tb_shift_reg_seq;
   import shreg_pkg::*;

   localparam int W  = 8;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   shift_reg_seq_if #(.WIDTH(W), .AMT_W(AW)) bus ();

   shift_reg_seq #(.WIDTH(W), .AMT_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      op_t          op;
      logic [AW-1:0] amt;
      logic [W-1:0] din;
      logic         sin;
      logic [W-1:0] exp_q;
      logic         exp_so;
      int           exp_lat;
   } vec_t;

   vec_t vt[10];
   int   nvec  = 0;
   int   nfail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called on a negedge with ready=1; returns on the negedge where done is seen.
   task automatic issue(input op_t op, input logic [AW-1:0] amt, input logic [W-1:0] din,
                        input logic sin, output int lat, output logic tmo);
      bus.start  = 1'b1;
      bus.op     = op;
      bus.amt    = amt;
      bus.din    = din;
      bus.ser_in = sin;
      @(posedge clk);
      #1 bus.start = 1'b0;
      lat = 0;
      tmo = 1'b0;
      @(negedge clk);
      while (bus.done !== 1'b1) begin
         if (lat > 100) begin
            tmo = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (bus.ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.ready !== 1'b1) chk({name, "_ready_timeout"}, 32'(bus.ready), 32'd1);
   endtask

   initial begin
      int   lat;
      logic tmo;
      int   dones;

      vt[0] = '{OP_LOAD, 4'd5,  8'hA5, 1'b0, 8'hA5, 1'b0, 0};
      vt[1] = '{OP_SHL,  4'd3,  8'h81, 1'b0, 8'h08, 1'b0, 3};
      vt[2] = '{OP_ROR,  4'd9,  8'h01, 1'b0, 8'h80, 1'b1, 9};
      vt[3] = '{OP_SHR,  4'd3,  8'h00, 1'b1, 8'hE0, 1'b0, 3};
      vt[4] = '{OP_SHR,  4'd0,  8'hA5, 1'b1, 8'hA5, 1'b0, 0};
      vt[5] = '{OP_SHL,  4'd15, 8'hFF, 1'b0, 8'h00, 1'b0, 15};
      vt[6] = '{OP_SHR,  4'd1,  8'h81, 1'b0, 8'h40, 1'b1, 1};
      vt[7] = '{OP_ROR,  4'd4,  8'h0F, 1'b0, 8'hF0, 1'b1, 4};
      vt[8] = '{OP_SHL,  4'd8,  8'h01, 1'b1, 8'hFF, 1'b1, 8};
      vt[9] = '{OP_ROR,  4'd15, 8'hA5, 1'b0, 8'h4B, 1'b0, 15};

      bus.start  = 1'b0;
      bus.op     = OP_LOAD;
      bus.amt    = '0;
      bus.din    = '0;
      bus.ser_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_q",     32'(bus.q),       32'h0);
      chk("rst_sout",  32'(bus.ser_out), 32'd0);
      chk("rst_ready", 32'(bus.ready),   32'd1);
      chk("rst_done",  32'(bus.done),    32'd0);

      for (int i = 0; i < 10; i++) begin
         wait_ready($sformatf("v%0d", i));
         issue(vt[i].op, vt[i].amt, vt[i].din, vt[i].sin, lat, tmo);
         chk($sformatf("v%0d_timeout", i), 32'(tmo), 32'd0);
         chk($sformatf("v%0d_lat", i),     32'(lat), 32'(vt[i].exp_lat));
         chk($sformatf("v%0d_q", i),       32'(bus.q), 32'(vt[i].exp_q));
         chk($sformatf("v%0d_sout", i),    32'(bus.ser_out), 32'(vt[i].exp_so));
         chk($sformatf("v%0d_rdy_in_done", i), 32'(bus.ready), 32'd0);
         @(negedge clk);
         chk($sformatf("v%0d_done_1cyc", i), 32'(bus.done),  32'd0);
         chk($sformatf("v%0d_ready_back", i), 32'(bus.ready), 32'd1);
         chk($sformatf("v%0d_q_hold", i),    32'(bus.q),     32'(vt[i].exp_q));
      end

      // SHL 81 by 3: the first step must push the MSB out on ser_out.
      wait_ready("shl_e1");
      bus.start = 1'b1; bus.op = OP_SHL; bus.amt = 4'd3; bus.din = 8'h81; bus.ser_in = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      chk("shl_e0_sout", 32'(bus.ser_out), 32'd0);
      @(negedge clk);
      chk("shl_e1_sout", 32'(bus.ser_out), 32'd1);
      chk("shl_e1_q",    32'(bus.q),       32'h02);
      repeat (2) @(negedge clk);
      chk("shl_e3_done", 32'(bus.done),    32'd1);
      chk("shl_e3_q",    32'(bus.q),       32'h08);
      @(negedge clk);

      // ser_in changing every step: fills 1,0,1,1 from the top.
      wait_ready("sin_var");
      bus.start = 1'b1; bus.op = OP_SHR; bus.amt = 4'd4; bus.din = 8'h00; bus.ser_in = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0; bus.ser_in = 1'b1;
      @(posedge clk);
      #1 bus.ser_in = 1'b0;
      @(posedge clk);
      #1 bus.ser_in = 1'b1;
      @(posedge clk);
      #1 bus.ser_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("sin_var_done", 32'(bus.done), 32'd1);
      chk("sin_var_q",    32'(bus.q),    32'hD0);
      @(negedge clk);

      // start pulsed during RUN must be ignored.
      wait_ready("ign");
      bus.start = 1'b1; bus.op = OP_ROR; bus.amt = 4'd9; bus.din = 8'h01; bus.ser_in = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 bus.start = 1'b1; bus.op = OP_LOAD; bus.amt = 4'd0; bus.din = 8'hFF;
      @(posedge clk);
      #1 bus.start = 1'b0;
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            dones++;
            chk("ign_q",    32'(bus.q),       32'h80);
            chk("ign_sout", 32'(bus.ser_out), 32'd1);
         end
      end
      chk("ign_done_count", 32'(dones), 32'd1);

      // Reset mid-RUN aborts with no done pulse; a following LOAD still works.
      wait_ready("rst_mid");
      bus.start = 1'b1; bus.op = OP_SHL; bus.amt = 4'd5; bus.din = 8'h81; bus.ser_in = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_q",     32'(bus.q),       32'h0);
      chk("rst_mid_sout",  32'(bus.ser_out), 32'd0);
      chk("rst_mid_ready", 32'(bus.ready),   32'd1);
      dones = 0;
      for (int c = 0; c < 8; c++) begin
         if (bus.done === 1'b1) dones++;
         @(negedge clk);
      end
      chk("rst_mid_no_done", 32'(dones), 32'd0);
      wait_ready("rst_load");
      issue(OP_LOAD, 4'd0, 8'h3C, 1'b0, lat, tmo);
      chk("rst_load_timeout", 32'(tmo), 32'd0);
      chk("rst_load_lat",     32'(lat), 32'd0);
      chk("rst_load_q",       32'(bus.q), 32'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
